// File: rtl/apu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// apu_frame_sequencer
//
// APU frame-sequencer timebase. A 3-bit step counter advances on each falling
// edge of the 512 Hz DIV tap. Each advance executes the current step and
// raises one-cycle strobes for the channel blocks:
//   len_tick   : steps 0,2,4,6  (256 Hz)
//   sweep_tick : steps 2,6      (128 Hz)
//   env_tick   : step 7         (64 Hz)
//
// Optional test mode (compile macro APU_FAST_SEQ_TEST_EN): when net03 is high,
// the sequencer advances from an internal prescaler every FAST_DIV clocks
// instead of on DIV edges. Without the macro, net03 and FAST_DIV are ignored.
//
// Ports:
//   apuv_4mhz  in   clock, all state updates on its rising edge
//   apu_reset  in   synchronous active-high reset (NR52 power-off)
//   div_bit    in   512 Hz DIV tap, already in the apuv_4mhz domain
//   net03      in   test-mode select (used only with APU_FAST_SEQ_TEST_EN)
//   step       out  current sequencer step (the next one to execute), 0..7
//   len_tick   out  length-counter strobe, one cycle wide
//   sweep_tick out  frequency-sweep strobe, one cycle wide
//   env_tick   out  volume-envelope strobe, one cycle wide
//
// Parameter:
//   FAST_DIV   test-mode prescaler period in clocks, legal range 2..256
// -----------------------------------------------------------------------------
module apu_frame_sequencer #(
    parameter int FAST_DIV = 16
) (
    input  logic       apuv_4mhz,
    input  logic       apu_reset,
    input  logic       div_bit,
    input  logic       net03,
    output logic [2:0] step,
    output logic       len_tick,
    output logic       sweep_tick,
    output logic       env_tick
);

    logic       r_div_q;
    logic [2:0] r_step;
    logic       r_len_tick;
    logic       r_sweep_tick;
    logic       r_env_tick;

    logic       w_div_fall;
    logic       w_adv;

    // div_q is loaded even during reset, so releasing reset with div_bit low
    // cannot look like a 1->0 transition.
    always_ff @(posedge apuv_4mhz) begin
        r_div_q <= div_bit;
    end

    assign w_div_fall = r_div_q & ~div_bit;

`ifdef APU_FAST_SEQ_TEST_EN
    // FAST_DIV is at most 256, so the terminal count always fits 8 bits.
    localparam logic [7:0] PRE_LAST = 8'(FAST_DIV - 1);

    logic [7:0] r_pre;
    logic       r_net03_q;
    logic       w_mode_flip;

    assign w_mode_flip = net03 ^ r_net03_q;

    // Test mode takes effect in the very cycle net03 rises, which masks a
    // coincident DIV edge. On the rising cycle r_pre is still 0 (held there
    // in normal mode), so no advance happens on that cycle either.
    assign w_adv = net03 ? (r_pre == PRE_LAST) : w_div_fall;

    always_ff @(posedge apuv_4mhz) begin
        r_net03_q <= net03;
        if (apu_reset) begin
            r_pre <= '0;
        end else if (!net03 || w_mode_flip || w_adv) begin
            // Held at 0 in normal mode, restarted on any mode change, and
            // wrapped on terminal count. Restarting on the entry cycle places
            // the first advance exactly FAST_DIV clocks after entry.
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 8'd1;
        end
    end
`else
    assign w_adv = w_div_fall;

    // net03 and FAST_DIV stay in the interface but have no function here.
    logic w_unused_net03;
    assign w_unused_net03 = net03;
    localparam int unused_fast_div = FAST_DIV;
`endif

    // Step execution. Reset wins over a coincident advance, so that advance
    // is dropped and the next one after release executes step 0.
    always_ff @(posedge apuv_4mhz) begin
        if (apu_reset) begin
            r_step       <= 3'd0;
            r_len_tick   <= 1'b0;
            r_sweep_tick <= 1'b0;
            r_env_tick   <= 1'b0;
        end else if (w_adv) begin
            r_len_tick   <= ~r_step[0];
            r_sweep_tick <= (r_step[1:0] == 2'b10);
            r_env_tick   <= (r_step == 3'd7);
            r_step       <= r_step + 3'd1;
        end else begin
            r_len_tick   <= 1'b0;
            r_sweep_tick <= 1'b0;
            r_env_tick   <= 1'b0;
        end
    end

    assign step       = r_step;
    assign len_tick   = r_len_tick;
    assign sweep_tick = r_sweep_tick;
    assign env_tick   = r_env_tick;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_apu_frame_sequencer
//
// Directed bench for apu_frame_sequencer. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point, i.e. they show the
// result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_apu_frame_sequencer;

    logic       clk;
    logic       rst;
    logic       div;
    logic       net03;
    logic [2:0] step;
    logic       len_t;
    logic       swp_t;
    logic       env_t;

    int checks = 0;
    int errors = 0;

    apu_frame_sequencer #(.FAST_DIV(16)) dut (
        .apuv_4mhz (clk),
        .apu_reset (rst),
        .div_bit   (div),
        .net03     (net03),
        .step      (step),
        .len_tick  (len_t),
        .sweep_tick(swp_t),
        .env_tick  (env_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two cycles high, then one edge with div low. Returns just after the
    // edge that samples div low, so the strobes of this advance are visible.
    task automatic div_fall();
        div = 1'b1;
        tick();
        tick();
        div = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        div = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        net03 = 1'b0;
        div   = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            div = (i == 1) ? 1'b1 : 1'b0;
            tick();
            checks++;
            if (step !== 3'd0 || {len_t, swp_t, env_t} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: step=%0d strobes=%b want step=0 strobes=000",
                         i, step, {len_t, swp_t, env_t});
            end
        end
        // Last reset cycle had div low; release with div still low.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (step !== 3'd0 || {len_t, swp_t, env_t} !== 3'b000) begin
                errors++;
                $display("FAIL reset_release cyc %0d: step=%0d strobes=%b want step=0 strobes=000",
                         i, step, {len_t, swp_t, env_t});
            end
        end
        // First genuine edge executes step 0.
        div_fall();
        checks++;
        if (step !== 3'd1 || {len_t, swp_t, env_t} !== 3'b100) begin
            errors++;
            $display("FAIL reset_first_edge: step=%0d strobes=%b want step=1 strobes=100",
                     step, {len_t, swp_t, env_t});
        end
    endtask

    task automatic test_full_frame();
        // Indexed by edge number 1..8 (index 0..7), hand-derived.
        logic [2:0] exp_step [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        logic [2:0] exp_stb  [8] = '{3'b100, 3'b000, 3'b110, 3'b000,
                                     3'b100, 3'b000, 3'b110, 3'b001};
        do_reset();
        for (int e = 0; e < 8; e++) begin
            div_fall();
            checks++;
            if (step !== exp_step[e] || {len_t, swp_t, env_t} !== exp_stb[e]) begin
                errors++;
                $display("FAIL frame_edge%0d: step=%0d strobes=%b want step=%0d strobes=%b",
                         e + 1, step, {len_t, swp_t, env_t}, exp_step[e], exp_stb[e]);
            end
            tick();
            checks++;
            if ({len_t, swp_t, env_t} !== 3'b000 || step !== exp_step[e]) begin
                errors++;
                $display("FAIL frame_width%0d: step=%0d strobes=%b want step=%0d strobes=000",
                         e + 1, step, {len_t, swp_t, env_t}, exp_step[e]);
            end
        end
    endtask

    task automatic test_wrap();
        int n_len = 0, n_swp = 0, n_env = 0, n_dbl = 0;
        logic [2:0] prev = 3'b000;
        logic [2:0] pat [16];
        do_reset();
        for (int e = 0; e < 16; e++) begin
            div = 1'b1;
            for (int c = 0; c < 3; c++) begin
                if (c == 2) div = 1'b0;
                tick();
                if (c == 2) pat[e] = {len_t, swp_t, env_t};
                n_len += int'(len_t);
                n_swp += int'(swp_t);
                n_env += int'(env_t);
                if ((prev & {len_t, swp_t, env_t}) != 3'b000) n_dbl++;
                prev = {len_t, swp_t, env_t};
            end
        end
        checks++;
        if (n_len != 8 || n_swp != 4 || n_env != 2) begin
            errors++;
            $display("FAIL wrap_counts: len=%0d sweep=%0d env=%0d want 8 4 2", n_len, n_swp, n_env);
        end
        checks++;
        if (n_dbl != 0) begin
            errors++;
            $display("FAIL wrap_width: double-wide strobes=%0d want 0", n_dbl);
        end
        for (int e = 0; e < 8; e++) begin
            checks++;
            if (pat[e + 8] !== pat[e]) begin
                errors++;
                $display("FAIL wrap_repeat edge%0d: strobes=%b want %b", e + 9, pat[e + 8], pat[e]);
            end
        end
        checks++;
        if (step !== 3'd0) begin
            errors++;
            $display("FAIL wrap_step: step=%0d want 0", step);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int e = 0; e < 5; e++) div_fall();
        checks++;
        if (step !== 3'd5) begin
            errors++;
            $display("FAIL mid_pre: step=%0d want 5", step);
        end
        // Falling edge coincides with reset.
        div = 1'b1;
        tick();
        div = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (step !== 3'd0 || {len_t, swp_t, env_t} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset: step=%0d strobes=%b want step=0 strobes=000",
                     step, {len_t, swp_t, env_t});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({len_t, swp_t, env_t} !== 3'b000) begin
            errors++;
            $display("FAIL mid_release: strobes=%b want 000", {len_t, swp_t, env_t});
        end
        div_fall();
        checks++;
        if (step !== 3'd1 || {len_t, swp_t, env_t} !== 3'b100) begin
            errors++;
            $display("FAIL mid_next: step=%0d strobes=%b want step=1 strobes=100",
                     step, {len_t, swp_t, env_t});
        end
    endtask

    task automatic test_glitch();
        int n = 0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            tick();
            n += int'(len_t | swp_t | env_t);
        end
        div = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            n += int'(len_t | swp_t | env_t);
        end
        checks++;
        if (n != 0 || step !== 3'd0) begin
            errors++;
            $display("FAIL static_div: strobe cycles=%0d step=%0d want 0 0", n, step);
        end
    endtask

    task automatic test_mode();
        int first_env = -1;
        int n = 0;
        do_reset();
        div = 1'b1;
        tick();
        net03 = 1'b1;
`ifdef APU_FAST_SEQ_TEST_EN
        // t counts edges after the entry edge; advances land on t=16,32,...
        for (int t = 0; t <= 170; t++) begin
            tick();
            if (env_t && first_env < 0) first_env = t;
            if (t == 15) begin
                checks++;
                if (step !== 3'd0 || len_t !== 1'b0) begin
                    errors++;
                    $display("FAIL tm_before16: step=%0d len=%b want 0 0", step, len_t);
                end
            end
            if (t == 16) begin
                checks++;
                if (step !== 3'd1 || {len_t, swp_t, env_t} !== 3'b100) begin
                    errors++;
                    $display("FAIL tm_at16: step=%0d strobes=%b want step=1 strobes=100",
                             step, {len_t, swp_t, env_t});
                end
            end
            if (t == 32) begin
                checks++;
                if (step !== 3'd2) begin
                    errors++;
                    $display("FAIL tm_at32: step=%0d want 2", step);
                end
            end
        end
        checks++;
        if (first_env != 128) begin
            errors++;
            $display("FAIL tm_env_time: first env at %0d want 128", first_env);
        end
        // Ten advances (t=16..160) leave step at 2.
        net03 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n += int'(len_t | swp_t | env_t);
        end
        checks++;
        if (step !== 3'd2 || n != 0) begin
            errors++;
            $display("FAIL tm_exit_hold: step=%0d strobe cycles=%0d want 2 0", step, n);
        end
        div_fall();
        checks++;
        if (step !== 3'd3 || {len_t, swp_t, env_t} !== 3'b110) begin
            errors++;
            $display("FAIL tm_exit_div: step=%0d strobes=%b want step=3 strobes=110",
                     step, {len_t, swp_t, env_t});
        end
        // DIV edge on the cycle net03 rises is masked.
        div = 1'b1;
        tick();
        div   = 1'b0;
        net03 = 1'b1;
        tick();
        checks++;
        if (step !== 3'd3 || {len_t, swp_t, env_t} !== 3'b000) begin
            errors++;
            $display("FAIL tm_entry_mask: step=%0d strobes=%b want step=3 strobes=000",
                     step, {len_t, swp_t, env_t});
        end
        net03 = 1'b0;
        tick();
`else
        for (int t = 0; t <= 200; t++) begin
            tick();
            n += int'(len_t | swp_t | env_t);
        end
        checks++;
        if (step !== 3'd0 || n != 0) begin
            errors++;
            $display("FAIL nomacro_static: step=%0d strobe cycles=%0d want 0 0", step, n);
        end
        div_fall();
        checks++;
        if (step !== 3'd1 || {len_t, swp_t, env_t} !== 3'b100) begin
            errors++;
            $display("FAIL nomacro_div1: step=%0d strobes=%b want step=1 strobes=100",
                     step, {len_t, swp_t, env_t});
        end
        div_fall();
        div_fall();
        checks++;
        if (step !== 3'd3 || {len_t, swp_t, env_t} !== 3'b110) begin
            errors++;
            $display("FAIL nomacro_div3: step=%0d strobes=%b want step=3 strobes=110",
                     step, {len_t, swp_t, env_t});
        end
        net03 = 1'b0;
        tick();
`endif
    endtask

    initial begin
        rst   = 1'b1;
        div   = 1'b0;
        net03 = 1'b0;
        test_reset();
        test_full_frame();
        test_wrap();
        test_reset_mid();
        test_glitch();
        test_mode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
